// File: rtl/aes_prng_reseed_seq.sv
// Reseed sequencer for the AES masking PRNGs. It counts blocks between reseeds and
// fetches EDN words to refill every channel's PRNG state before a new block may start.
module aes_prng_reseed_seq #(
  parameter int EntropyWidth  = 32,
  parameter int StateWidth    = 177,
  parameter int NumChannels   = 2,
  parameter int BlockCtrWidth = 14,
  localparam int NumStateParts = (StateWidth + EntropyWidth - 1) / EntropyWidth,
  localparam int PartWidth     = $clog2(NumStateParts)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              reseed_rate_i,
  input  logic                    force_reseed_i,
  input  logic                    start_i,
  output logic                    start_gnt_o,
  input  logic                    block_done_i,
  input  logic                    alert_fatal_i,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i,
  output logic [NumChannels-1:0]  seed_we_o,
  output logic [PartWidth-1:0]    seed_part_o,
  output logic [EntropyWidth-1:0] seed_data_o,
  output logic                    busy_o,
  output logic                    ctr_expired_o,
  output logic                    reseed_done_o,
  output logic                    err_o
);

  localparam int NumBitsLastPart = StateWidth - (NumStateParts - 1) * EntropyWidth;
  localparam int TotalWords      = NumChannels * NumStateParts;
  localparam int ChWidth         = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int AckCntWidth     = $clog2(TotalWords + 1);
  localparam logic [EntropyWidth-1:0] LastPartMask =
      {EntropyWidth{1'b1}} >> (EntropyWidth - NumBitsLastPart);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERROR} state_e;

  state_e                   state_reg, state_next;
  logic                     req_reg;
  logic [BlockCtrWidth-1:0] block_ctr_reg, block_ctr_next;
  logic                     pending_reg, pending_next;
  logic                     again_reg, again_next;
  logic [PartWidth-1:0]     part_reg, part_next;
  logic [ChWidth-1:0]       ch_reg, ch_next;
  logic [AckCntWidth-1:0]   ack_cnt_reg;
  logic [BlockCtrWidth-1:0] reload_val;
  logic                     ctr_expired, fetch_ack, last_part, last_ch;

  assign ctr_expired = (block_ctr_reg == '0);
  assign fetch_ack   = (state_reg == FETCH) && entropy_ack_i;
  assign last_part   = (part_reg == PartWidth'(NumStateParts - 1));
  assign last_ch     = (ch_reg == ChWidth'(NumChannels - 1));

  always_comb begin
    case (reseed_rate_i)
      2'b00:   reload_val = BlockCtrWidth'(1);
      2'b01:   reload_val = BlockCtrWidth'(64);
      default: reload_val = BlockCtrWidth'(8192);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    block_ctr_next = block_ctr_reg;
    pending_next   = pending_reg;
    again_next     = again_reg;
    part_next      = part_reg;
    ch_next        = ch_reg;
    start_gnt_o    = 1'b0;
    reseed_done_o  = 1'b0;
    if (block_done_i && !ctr_expired) begin
      block_ctr_next = block_ctr_reg - BlockCtrWidth'(1);
    end
    case (state_reg)
      IDLE: begin
        part_next   = '0;
        ch_next     = '0;
        start_gnt_o = start_i && !ctr_expired && !pending_reg && !alert_fatal_i;
        if (force_reseed_i) pending_next = 1'b1;
        if (start_i && (ctr_expired || pending_reg)) state_next = FETCH;
      end
      FETCH: begin
        // A force arriving mid-sequence must survive the clear in DONE.
        if (force_reseed_i) begin
          pending_next = 1'b1;
          again_next   = 1'b1;
        end
        if (entropy_ack_i) begin
          if (last_part) begin
            part_next = '0;
            ch_next   = last_ch ? '0 : ch_reg + ChWidth'(1);
            if (last_ch) state_next = DONE;
          end else begin
            part_next = part_reg + PartWidth'(1);
          end
        end
      end
      DONE: begin
        reseed_done_o  = 1'b1;
        block_ctr_next = reload_val;
        pending_next   = again_reg || force_reseed_i;
        again_next     = 1'b0;
        state_next     = IDLE;
      end
      default: ;
    endcase
    if (alert_fatal_i) state_next = ERROR;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      block_ctr_reg <= '0;
      pending_reg   <= 1'b0;
      again_reg     <= 1'b0;
      part_reg      <= '0;
      ch_reg        <= '0;
      ack_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= (state_next == FETCH);
      block_ctr_reg <= block_ctr_next;
      pending_reg   <= pending_next;
      again_reg     <= again_next;
      part_reg      <= part_next;
      ch_reg        <= ch_next;
      if (state_reg == IDLE) ack_cnt_reg <= '0;
      else if (fetch_ack)    ack_cnt_reg <= ack_cnt_reg + AckCntWidth'(1);
    end
  end

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_we
    assign seed_we_o[gi] = fetch_ack && (ch_reg == ChWidth'(gi));
  end

  assign seed_part_o   = fetch_ack ? part_reg : '0;
  assign seed_data_o   = !fetch_ack ? '0 : (last_part ? (entropy_i & LastPartMask) : entropy_i);
  assign entropy_req_o = req_reg;
  assign busy_o        = (state_reg == FETCH) || (state_reg == DONE);
  assign ctr_expired_o = ctr_expired;
  assign err_o         = (state_reg == ERROR);

  a_one_part_per_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    fetch_ack |-> $onehot(seed_we_o));
  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (entropy_req_o && !entropy_ack_i && !alert_fatal_i) |=> entropy_req_o);
  a_ack_count: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_reg == DONE) |-> (ack_cnt_reg == AckCntWidth'(TotalWords)));

endmodule

// File: doc/aes_prng_reseed_seq.md
Name: aes_prng_reseed_seq

Overview:
- Parametrised reseed sequencer for the AES masking PRNGs. It supports multiple PRNG channels and generic entropy/state widths.
- Tracks a per-block reseed counter with a software-selectable rate and accepts forced reseed requests.
- When a reseed is due, fetches enough EDN words to refill every channel's full PRNG state, then grants the block start.
- Sits between the AES control FSM, the EDN endpoint and the masking PRNG state registers.

Parameters:
- EntropyWidth, 32, width of one EDN word.
- StateWidth, 177, PRNG state width per channel (Bivium default).
- NumChannels, 2, number of independent PRNG channels reseeded per sequence.
- BlockCtrWidth, 14, block counter width; must hold 8192.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset (asynchronous, active-high)
- reseed_rate_i  in  2  reload value select: 00→1, 01→64, 10→8192, 11→8192
- force_reseed_i  in  1  one-cycle pulse; requests a reseed before the next block
- start_i  in  1  control FSM requests a new block (level, held until granted)
- start_gnt_o  out  1  block may start; combinational
- block_done_i  in  1  one-cycle pulse; one block finished
- alert_fatal_i  in  1  fatal alert
- entropy_req_o  out  1  EDN request
- entropy_ack_i  in  1  EDN acknowledge; data is valid in the same cycle
- entropy_i  in  EntropyWidth  EDN data
- seed_we_o  out  NumChannels  one-hot write strobe to a PRNG state part
- seed_part_o  out  $clog2(NumStateParts)  part index being written
- seed_data_o  out  EntropyWidth  part data; bits at and above NumBitsLastPart are zero for the last part
- busy_o  out  1  reseed in progress
- ctr_expired_o  out  1  block counter is zero
- reseed_done_o  out  1  one-cycle pulse after a completed sequence
- err_o  out  1  terminal error state

Behaviour:
- Derived constants:
  - NumStateParts = ceil(StateWidth/EntropyWidth).
  - NumBitsLastPart = StateWidth - (NumStateParts-1)*EntropyWidth.
  - TotalWords = NumChannels*NumStateParts.
  - Defaults give 6 parts, 17 bits in the last part, 12 words.
- Reset values: state IDLE, block_ctr=0 (expired, so the first block always reseeds), pending=0. All outputs 0 except ctr_expired_o=1.
- FSM states: IDLE, FETCH, DONE, ERROR.
- IDLE:
  - Enter FETCH on the next edge when start_i && (ctr_expired || pending).
  - start_gnt_o = start_i && !ctr_expired && !pending && !alert_fatal_i, in IDLE only.
- FETCH:
  - entropy_req_o is registered high, from the first FETCH cycle through the cycle of the final ack.
  - It stays high continuously between words, deasserts the cycle after the final ack, and is never dropped before ack.
  - On each ack cycle, seed_we_o[ch], seed_part_o=part and seed_data_o are driven combinationally from entropy_i, masked for the last part.
  - Walk order: part increments first, then channel; both wrap to 0.
  - After the ack of ch=NumChannels-1 and part=NumStateParts-1, move to DONE.
- DONE (one cycle):
  - reseed_done_o=1, block_ctr reloads from reseed_rate_i as sampled now, pending clears.
  - Next state is IDLE. start_gnt_o can assert the following cycle.
- Counter:
  - block_done_i decrements block_ctr, saturating at 0.
  - If a reload and block_done_i coincide, the reload wins.
  - A change to reseed_rate_i has effect only at the next reload.
- force_reseed_i:
  - In IDLE or DONE: sets pending.
  - In FETCH: sets pending, but the DONE clear does not drop it. Exactly one further full sequence follows on the next start_i.
- Bit 0 of busy_o is high in FETCH and DONE.
- alert_fatal_i, in any state: go to ERROR on the next edge.
  - ERROR is terminal until rst_i.
  - entropy_req_o, seed_we_o and start_gnt_o are forced 0 from the next cycle.
  - err_o=1.
  - A partially written state is not completed.
- Asserting rst_i mid-FETCH returns to IDLE asynchronously with req=0. The counter returns to 0, so the next start reseeds again.
- Latency: with ack tied high, start_i→first req is 1 cycle, TotalWords ack cycles follow, then DONE, then grant. With defaults this is grant 14 cycles after start_i.
- Assertions to carry:
  - Each ack cycle writes exactly one part.
  - req high and no ack |=> req high.
  - The ack count per sequence equals TotalWords.

Test Plan:
- Reset release, start_i=1, ack tied high, defaults:
  - 12 seed_we_o pulses in order ch0 p0..p5, then ch1 p0..p5.
  - reseed_done_o at cycle 13, start_gnt_o at cycle 14.
  - Last-part seed_data_o[31:17]=0.
- rate=01, then 64 start/block_done pairs:
  - No entropy_req_o for blocks 1..64.
  - The 65th start_i triggers a full reseed; ctr_expired_o rises after the 64th block_done_i.
- EDN back-pressure, ack pulsed every 5th cycle:
  - req stays continuously high.
  - Exactly 12 writes occur.
  - reseed_done_o comes 1 cycle after the 12th ack.
- force_reseed_i pulsed during word 4 of a sequence:
  - The sequence completes and grant is withheld.
  - A second 12-word sequence runs.
  - Then start_gnt_o=1 and pending=0.
- alert_fatal_i during word 7:
  - req and we are 0 the next cycle, err_o=1 permanently, no reseed_done_o.
  - After rst_i pulse: ctr_expired_o=1, IDLE.
- NumChannels=3, StateWidth=288, EntropyWidth=64:
  - 5 parts of which the last has 32 bits; 15 writes.
  - Last-part data[63:32]=0.
